requant_packer: RTL and testbench

- Producer for the ReLU stage. Takes 32-bit signed partial sums from the accumulator array, 4 lanes per beat.
- Per lane: requantizes to int8 with a rounding arithmetic right shift, then saturates.
- Packs 4 beats into one 128-bit word of 16 int8 lanes. Emits it on a valid-only interface that feeds the ReLU DI_valid/DI inputs directly.
- Counts words per layer tile and signals done.

---
 rtl/requant_packer_pkg.sv | 26 ++
 rtl/requant_lane.sv | 38 +++
 rtl/requant_packer.sv | 136 +++++++++++++
 tb/tb_requant_packer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/requant_packer_pkg.sv
// Shared widths, state encoding and legacy width macros for requant_packer.
// Honours REQUANT_ZP_EN in the files that import this package.
`ifndef REQUANT_PACKER_DEFINES
`define REQUANT_PACKER_DEFINES
`define WORD_SIZE 128
`define DATA_SIZE 8
`define PSUM_SIZE 32
`define LANES_PER_BEAT 4
`define BEATS_PER_WORD 4
`endif

package requant_packer_pkg;

  localparam int unsigned PSUM_W         = `PSUM_SIZE;
  localparam int unsigned DATA_W         = `DATA_SIZE;
  localparam int unsigned LANES_PER_BEAT = `LANES_PER_BEAT;
  localparam int unsigned BEATS_PER_WORD = `BEATS_PER_WORD;
  localparam int unsigned BEAT_W         = LANES_PER_BEAT * DATA_W;
  localparam int unsigned STAGE_W        = (BEATS_PER_WORD - 1) * BEAT_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/requant_lane.sv
// One lane: rounding arithmetic right shift of a signed psum, then int8 saturation.
// REQUANT_ZP_EN adds a signed zero-point applied before saturation.
module requant_lane
  import requant_packer_pkg::*;
(
  input  logic [PSUM_W-1:0] psum_i,
  input  logic [4:0]        shift_i,
`ifdef REQUANT_ZP_EN
  input  logic [DATA_W-1:0] zp_i,
`endif
  output logic [DATA_W-1:0] q_o
);

  localparam logic signed [PSUM_W+1:0] SAT_MAX = 34'sd127;
  localparam logic signed [PSUM_W+1:0] SAT_MIN = -34'sd128;

  logic signed [PSUM_W:0]   rnd;
  logic signed [PSUM_W:0]   t;
  logic signed [PSUM_W:0]   q;
  logic signed [PSUM_W+1:0] v;

  always_comb begin
    rnd = '0;
    if (shift_i != 5'd0) rnd[shift_i - 5'd1] = 1'b1;
    // One guard bit keeps psum + half-LSB from wrapping at the positive limit.
    t = $signed({psum_i[PSUM_W-1], psum_i}) + rnd;
    q = t >>> shift_i;
`ifdef REQUANT_ZP_EN
    v = {q[PSUM_W], q} + {{(PSUM_W + 2 - DATA_W){zp_i[DATA_W-1]}}, zp_i};
`else
    v = {q[PSUM_W], q};
`endif
    if (v > SAT_MAX)      q_o = 8'h7F;
    else if (v < SAT_MIN) q_o = 8'h80;
    else                  q_o = v[DATA_W-1:0];
  end

endmodule

// File: rtl/requant_packer.sv
// Requantizes 4-lane psum beats to int8 and packs 4 beats per 128-bit output word.
// Optional signed zero-point input cfg_zp when REQUANT_ZP_EN is defined.
module requant_packer
  import requant_packer_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [4:0]                             cfg_shift,
  input  logic [15:0]                            cfg_words,
`ifdef REQUANT_ZP_EN
  input  logic [7:0]                             cfg_zp,
`endif
  input  logic                                   PI_valid,
  input  logic [`LANES_PER_BEAT*`PSUM_SIZE-1:0]  PI,
  output logic                                   DO_valid,
  output logic [`WORD_SIZE-1:0]                  DO,
  output logic                                   busy,
  output logic                                   done
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_WORD - 1);

  state_e               state_q, state_d;
  logic [1:0]           beat_cnt_q, beat_cnt_d;
  logic [15:0]          word_cnt_q, word_cnt_d;
  logic [15:0]          words_q, words_d;
  logic [4:0]           shift_q, shift_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [`WORD_SIZE-1:0] do_q, do_d;
  logic                 do_valid_q, do_valid_d;
  logic                 done_q, done_d;
  logic [BEAT_W-1:0]    beat_lanes;
`ifdef REQUANT_ZP_EN
  logic [7:0]           zp_q, zp_d;
`endif

  for (genvar k = 0; k < LANES_PER_BEAT; k++) begin : g_lane
    requant_lane u_lane (
      .psum_i  (PI[k*PSUM_W +: PSUM_W]),
      .shift_i (shift_q),
`ifdef REQUANT_ZP_EN
      .zp_i    (zp_q),
`endif
      .q_o     (beat_lanes[k*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    word_cnt_d = word_cnt_q;
    words_d    = words_q;
    shift_d    = shift_q;
    stage_d    = stage_q;
    do_d       = do_q;
    do_valid_d = 1'b0;
    done_d     = 1'b0;
`ifdef REQUANT_ZP_EN
    zp_d       = zp_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = cfg_shift;
          words_d    = cfg_words;
`ifdef REQUANT_ZP_EN
          zp_d       = cfg_zp;
`endif
          beat_cnt_d = '0;
          word_cnt_d = '0;
          stage_d    = '0;
          if (cfg_words == 16'd0) done_d = 1'b1;
          else                    state_d = RUN;
        end
      end
      RUN: begin
        if (PI_valid) begin
          if (beat_cnt_q == LAST_BEAT) begin
            // The final beat bypasses staging and goes straight into the output word.
            do_d       = {beat_lanes, stage_q};
            do_valid_d = 1'b1;
            beat_cnt_d = '0;
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_d == words_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            for (int unsigned b = 0; b < BEATS_PER_WORD - 1; b++) begin
              if (beat_cnt_q == b[1:0]) stage_d[b*BEAT_W +: BEAT_W] = beat_lanes;
            end
            beat_cnt_d = beat_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      word_cnt_q <= '0;
      words_q    <= '0;
      shift_q    <= '0;
      stage_q    <= '0;
      do_q       <= '0;
      do_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef REQUANT_ZP_EN
      zp_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      word_cnt_q <= word_cnt_d;
      words_q    <= words_d;
      shift_q    <= shift_d;
      stage_q    <= stage_d;
      do_q       <= do_d;
      do_valid_q <= do_valid_d;
      done_q     <= done_d;
`ifdef REQUANT_ZP_EN
      zp_q       <= zp_d;
`endif
    end
  end

  assign DO       = do_q;
  assign DO_valid = do_valid_q;
  assign done     = done_q;
  assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_requant_packer.sv
// Directed bench for requant_packer: vector table for single-word requant cases
// plus hand sequences for gaps, mid-word reset, corner starts and zero-point.
module tb_requant_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   cfg_shift = '0;
  logic [15:0]  cfg_words = '0;
`ifdef REQUANT_ZP_EN
  logic [7:0]   cfg_zp = '0;
`endif
  logic         PI_valid = 1'b0;
  logic [127:0] PI = '0;
  logic         DO_valid;
  logic [127:0] DO;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  requant_packer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_shift (cfg_shift),
    .cfg_words (cfg_words),
`ifdef REQUANT_ZP_EN
    .cfg_zp    (cfg_zp),
`endif
    .PI_valid  (PI_valid),
    .PI        (PI),
    .DO_valid  (DO_valid),
    .DO        (DO),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (DO_valid) vcount++;

  typedef struct {
    int          shift;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [4:0] sh, input logic [15:0] words);
    cfg_shift = sh;
    cfg_words = words;
`ifdef REQUANT_ZP_EN
    cfg_zp = 8'h00;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [31:0] p3);
    PI_valid = 1'b1;
    PI = {p3, p2, p1, p0};
    tick();
    PI_valid = 1'b0;
    PI = '0;
  endtask

  initial begin
    logic [127:0] exp_w;
    int v0;

    vecs[0] = '{shift: 0,  p0: 5,            p1: -3,           p2: 200, p3: -200, exp: 32'h807FFD05};
    vecs[1] = '{shift: 4,  p0: 24,           p1: -24,          p2: 7,   p3: -9,   exp: 32'hFF00FF02};
    vecs[2] = '{shift: 31, p0: 32'h7FFFFFFF, p1: 32'h80000000, p2: 0,   p3: -1,   exp: 32'h0000FF01};
    vecs[3] = '{shift: 1,  p0: 3,            p1: -3,           p2: 255, p3: -256, exp: 32'h807FFF02};
    vecs[4] = '{shift: 8,  p0: 32767,        p1: -32768,       p2: 383, p3: 384,  exp: 32'h0201807F};

    rst = 1'b0;
    tick();
    tick();
    check("reset DO", DO, '0);
    check1("reset DO_valid", DO_valid, 1'b0);
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      do_start(vecs[i].shift[4:0], 16'd1);
      check1($sformatf("vec%0d busy", i), busy, 1'b1);
      send_beat(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3);
      send_beat(0, 0, 0, 0);
      send_beat(0, 0, 0, 0);
      check1($sformatf("vec%0d early valid", i), DO_valid, 1'b0);
      send_beat(0, 0, 0, 0);
      check1($sformatf("vec%0d DO_valid", i), DO_valid, 1'b1);
      check($sformatf("vec%0d lanes0-3", i), {96'd0, DO[31:0]}, {96'd0, vecs[i].exp});
      check($sformatf("vec%0d upper lanes", i), {32'd0, DO[127:32]}, '0);
      check1($sformatf("vec%0d done", i), done, 1'b1);
      tick();
      check1($sformatf("vec%0d valid pulse", i), DO_valid, 1'b0);
      check($sformatf("vec%0d DO hold", i), {96'd0, DO[31:0]}, {96'd0, vecs[i].exp});
    end

    // Two words, lane value = global lane index, random gaps.
    v0 = vcount;
    do_start(5'd0, 16'd2);
    for (int b = 0; b < 8; b++) begin
      repeat ($urandom_range(3, 0)) tick();
      send_beat(4*b, 4*b + 1, 4*b + 2, 4*b + 3);
      if (b % 4 == 3) begin
        for (int j = 0; j < 16; j++) exp_w[8*j +: 8] = 8'(j + 16*(b/4));
        check1($sformatf("mw word%0d valid", b/4), DO_valid, 1'b1);
        check($sformatf("mw word%0d data", b/4), DO, exp_w);
        check1($sformatf("mw word%0d done", b/4), done, (b == 7));
      end else begin
        check1($sformatf("mw beat%0d no valid", b), DO_valid, 1'b0);
      end
    end
    tick();
    check1("mw busy after done", busy, 1'b0);
    tick();
    check("mw word count", 128'(vcount - v0), 128'd2);

    // Beats after the tile end are ignored.
    v0 = vcount;
    for (int b = 0; b < 4; b++) send_beat(9, 9, 9, 9);
    tick();
    tick();
    check("idle beats ignored", 128'(vcount - v0), 128'd0);
    check1("idle busy", busy, 1'b0);

    // Reset mid-word discards partial staging.
    do_start(5'd0, 16'd1);
    send_beat(50, 50, 50, 50);
    send_beat(50, 50, 50, 50);
    v0 = vcount;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst DO", DO, '0);
    check1("midrst DO_valid", DO_valid, 1'b0);
    check1("midrst busy", busy, 1'b0);
    check1("midrst done", done, 1'b0);
    tick();
    do_start(5'd0, 16'd1);
    send_beat(3, 3, 3, 3);
    send_beat(3, 3, 3, 3);
    send_beat(3, 3, 3, 3);
    check1("midrst no early word", DO_valid, 1'b0);
    send_beat(3, 3, 3, 3);
    check1("midrst new valid", DO_valid, 1'b1);
    check("midrst new data", DO, {16{8'h03}});
    check("midrst word count", 128'(vcount - v0), 128'd0);
    tick();

    // cfg_words == 0 completes immediately.
    v0 = vcount;
    do_start(5'd0, 16'd0);
    check1("zero words done", done, 1'b1);
    check1("zero words busy", busy, 1'b0);
    tick();
    check1("zero words done pulse", done, 1'b0);
    tick();
    check("zero words no DO", 128'(vcount - v0), 128'd0);

    // start while busy is ignored.
    do_start(5'd0, 16'd2);
    for (int b = 0; b < 4; b++) send_beat(1, 1, 1, 1);
    check1("busy-start word1 done", done, 1'b0);
    send_beat(2, 2, 2, 2);
    send_beat(2, 2, 2, 2);
    cfg_shift = 5'd4;
    cfg_words = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check1("busy-start still busy", busy, 1'b1);
    send_beat(2, 2, 2, 2);
    send_beat(2, 2, 2, 2);
    check1("busy-start word2 valid", DO_valid, 1'b1);
    check1("busy-start word2 done", done, 1'b1);
    check("busy-start word2 data", DO, {16{8'h02}});
    tick();

`ifdef REQUANT_ZP_EN
    cfg_shift = 5'd0;
    cfg_words = 16'd1;
    cfg_zp = 8'hF6;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_beat(130, -125, 0, 100);
    send_beat(0, 0, 0, 0);
    send_beat(0, 0, 0, 0);
    send_beat(0, 0, 0, 0);
    check1("zp valid", DO_valid, 1'b1);
    check("zp lanes0-3", {96'd0, DO[31:0]}, {96'd0, 32'h5AF68078});
    check("zp upper lanes", {32'd0, DO[127:32]}, {32'd0, {12{8'hF6}}});
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
